priority_grant_ctrl: RTL and testbench

PRIORITY_GRANT_CTRL -- requirements
Module: priority_grant_ctrl

---
 rtl/priority_grant_ctrl_pkg.sv | 27 ++
 rtl/grant_timer.sv | 34 +++
 rtl/priority_grant_ctrl.sv | 156 +++++++++++++++
 tb/tb_priority_grant_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_grant_ctrl_pkg.sv
// Shared types and constants for the priority grant controller.
//   state_e     : controller state (IDLE, GRANT, GUARD)
//   GNT_W       : width of the one-hot grant vector
//   IDX_W       : width of the encoded requester index
//   CNT_W       : width of the completed-grant counter
//   idx_to_gnt(): maps an encoded index to its one-hot grant bit (bit 3 - idx)
package priority_grant_ctrl_pkg;

    localparam int unsigned GNT_W = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_e;

    // Index 0 is the highest-order grant line: 0 -> 1000, 3 -> 0001.
    function automatic logic [GNT_W-1:0] idx_to_gnt(input logic [IDX_W-1:0] idx);
        logic [GNT_W-1:0] w_onehot;
        w_onehot = '0;
        w_onehot[(GNT_W-1) - int'(idx)] = 1'b1;
        return w_onehot;
    endfunction

endpackage

// File: rtl/grant_timer.sv
// Cycle counter shared by the GRANT wait timer and the GUARD spacing timer.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset, clears the count
//   i_load    : restart the count from zero (state entry)
//   i_en      : advance the count by one
//   i_limit   : last count value of the current interval
//   o_expired : count has reached i_limit (this is the interval's final cycle)
module grant_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/priority_grant_ctrl.sv
// Single-grant controller fed by an upstream priority encoder.
// Accepts one request in IDLE, holds a one-hot grant until ack or timeout,
// then enforces a guard gap before the next request is sampled.
// Parameters:
//   TIMEOUT_CYC : grant cycles without ack before the grant is revoked (2..255)
//   GUARD_CYC   : idle guard cycles after each grant ends (1..15)
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   enc_y       : encoded requester index
//   enc_valid   : enc_y is meaningful (sampled in IDLE only)
//   ack         : requester completes the current grant (used in GRANT only)
//   gnt         : one-hot grant, bit (3 - index)
//   gnt_idx     : index of the current or most recent grant
//   busy        : controller is not in IDLE
//   timeout_err : one-cycle pulse when a grant is revoked by timeout
//   done_cnt    : modulo-256 count of grants completed by ack
module priority_grant_ctrl
    import priority_grant_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 8,
    parameter int unsigned GUARD_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] enc_y,
    input  logic             enc_valid,
    input  logic             ack,
    output logic [GNT_W-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] done_cnt
);

    // The timer only ever needs to hold TIMEOUT_CYC-1 or GUARD_CYC-1.
    localparam int unsigned TIMER_MAX = (TIMEOUT_CYC > GUARD_CYC) ? TIMEOUT_CYC : GUARD_CYC;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] WAIT_LAST  = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] GUARD_LAST = TIMER_W'(GUARD_CYC - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [GNT_W-1:0] r_gnt;
    logic [GNT_W-1:0] w_gnt_d;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_d;
    logic             r_busy;
    logic             w_busy_d;
    logic             r_timeout_err;
    logic             w_timeout_err_d;
    logic [CNT_W-1:0] r_done_cnt;
    logic [CNT_W-1:0] w_done_cnt_d;

    logic               w_tmr_load;
    logic               w_tmr_en;
    logic [TIMER_W-1:0] w_tmr_limit;
    logic               w_tmr_expired;

    // Timer limit follows the current state; in IDLE the value is irrelevant.
    assign w_tmr_limit = (r_state == GUARD) ? GUARD_LAST : WAIT_LAST;

    grant_timer #(
        .WIDTH (TIMER_W)
    ) u_grant_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_tmr_load),
        .i_en      (w_tmr_en),
        .i_limit   (w_tmr_limit),
        .o_expired (w_tmr_expired)
    );

    always_comb begin
        w_state_d       = r_state;
        w_gnt_d         = r_gnt;
        w_gnt_idx_d     = r_gnt_idx;
        w_timeout_err_d = 1'b0;
        w_done_cnt_d    = r_done_cnt;
        w_tmr_load      = 1'b0;
        w_tmr_en        = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_gnt_d = '0;
                if (enc_valid) begin
                    w_state_d   = GRANT;
                    w_gnt_idx_d = enc_y;
                    w_gnt_d     = idx_to_gnt(enc_y);
                    w_tmr_load  = 1'b1;
                end
            end
            GRANT: begin
                // ack takes priority over a timeout landing in the same cycle.
                if (ack) begin
                    w_state_d    = GUARD;
                    w_gnt_d      = '0;
                    w_done_cnt_d = r_done_cnt + 1'b1;
                    w_tmr_load   = 1'b1;
                end else if (w_tmr_expired) begin
                    w_state_d       = GUARD;
                    w_gnt_d         = '0;
                    w_timeout_err_d = 1'b1;
                    w_tmr_load      = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            GUARD: begin
                w_gnt_d = '0;
                if (w_tmr_expired) begin
                    w_state_d = IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_gnt_d   = '0;
            end
        endcase

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_gnt_idx     <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_done_cnt    <= '0;
        end else begin
            r_state       <= w_state_d;
            r_gnt         <= w_gnt_d;
            r_gnt_idx     <= w_gnt_idx_d;
            r_busy        <= w_busy_d;
            r_timeout_err <= w_timeout_err_d;
            r_done_cnt    <= w_done_cnt_d;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_idx     = r_gnt_idx;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign done_cnt    = r_done_cnt;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
    a_gnt_only_in_grant : assert property (
        @(posedge clk) disable iff (rst) (r_gnt != '0) |-> (r_state == GRANT)
    );

endmodule

// File: tb/tb_priority_grant_ctrl.sv
module tb_priority_grant_ctrl;

    localparam int unsigned T = 8;
    localparam int unsigned G = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] enc_y = 2'd0;
    logic       enc_valid = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout_err;
    logic [7:0] done_cnt;

    int errors = 0;
    int checks = 0;

    priority_grant_ctrl #(
        .TIMEOUT_CYC (T),
        .GUARD_CYC   (G)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enc_y       (enc_y),
        .enc_valid   (enc_valid),
        .ack         (ack),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .busy        (busy),
        .timeout_err (timeout_err),
        .done_cnt    (done_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a grant is "on" for an age of 1..T cycles, then a
    // guard countdown of G cycles runs before a new request is sampled.
    logic       m_on = 1'b0;
    int         m_age = 0;
    int         m_guard = 0;
    logic [1:0] m_idx = 2'd0;
    logic [7:0] m_done = 8'd0;
    logic       m_to = 1'b0;
    logic [3:0] e_gnt;
    logic       e_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on <= 1'b0; m_age <= 0; m_guard <= 0; m_idx <= 2'd0; m_done <= 8'd0; m_to <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_guard > 0) begin
                m_guard <= m_guard - 1;
            end else if (m_on) begin
                if (ack) begin
                    m_on <= 1'b0; m_done <= m_done + 8'd1; m_guard <= G;
                end else if (m_age == T) begin
                    m_on <= 1'b0; m_to <= 1'b1; m_guard <= G;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (enc_valid) begin
                m_on <= 1'b1; m_age <= 1; m_idx <= enc_y;
            end
        end
    end

    always_comb begin
        e_gnt  = m_on ? (4'b1000 >> m_idx) : 4'b0000;
        e_busy = m_on || (m_guard != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        enc_valid = 1'b0; ack = 1'b0; enc_y = 2'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        enc_y = 2'd2; enc_valid = 1'b1; ack = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, gnt_idx, busy, timeout_err, done_cnt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_async got gnt=%b idx=%0d busy=%b to=%b done=%0d exp all 0",
                     gnt, gnt_idx, busy, timeout_err, done_cnt);
        end
        tick(); tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got gnt=%b busy=%b exp 0000/0", gnt, busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0010 || busy !== 1'b1 || gnt_idx !== 2'd2) begin
            errors++;
            $display("FAIL reset_release_grant got gnt=%b busy=%b idx=%0d exp 0010/1/2",
                     gnt, busy, gnt_idx);
        end
    endtask

    task automatic test_ack_grant();
        int hi = 0;
        apply_reset();
        enc_y = 2'd0; enc_valid = 1'b1;
        tick();
        enc_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (gnt == 4'b1000) hi++;
            if (i == 3) ack = 1'b1;
            if (i < 3) tick();
        end
        tick();
        ack = 1'b0;
        checks++;
        if (hi != 3) begin
            errors++;
            $display("FAIL ack_grant_len got=%0d exp=3", hi);
        end
        checks++;
        if (gnt !== 4'b0000 || done_cnt !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ack_guard got gnt=%b done=%0d busy=%b exp 0000/1/1", gnt, done_cnt, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL ack_idle got busy=%b idx=%0d exp 0/0", busy, gnt_idx);
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        int pulses = 0;
        apply_reset();
        enc_y = 2'd2; enc_valid = 1'b1;
        tick();
        enc_valid = 1'b0;
        for (int i = 0; i < int'(T + G) + 4; i++) begin
            if (gnt != 4'b0000) hi++;
            if (timeout_err) pulses++;
            tick();
        end
        checks++;
        if (hi != int'(T)) begin
            errors++;
            $display("FAIL timeout_len got=%0d exp=%0d", hi, T);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL timeout_pulse got=%0d exp=1", pulses);
        end
        checks++;
        if (done_cnt !== 8'd0 || gnt_idx !== 2'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after got done=%0d idx=%0d busy=%b exp 0/2/0",
                     done_cnt, gnt_idx, busy);
        end
    endtask

    task automatic test_ack_at_timeout();
        int pulses = 0;
        apply_reset();
        enc_y = 2'd1; enc_valid = 1'b1;
        tick();
        enc_valid = 1'b0;
        for (int i = 1; i < int'(T); i++) tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL last_cycle_gnt got=%b exp=0100", gnt);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < int'(G) + 3; i++) begin
            if (timeout_err) pulses++;
            tick();
        end
        checks++;
        if (done_cnt !== 8'd1 || pulses != 0) begin
            errors++;
            $display("FAIL ack_wins got done=%0d pulses=%0d exp 1/0", done_cnt, pulses);
        end
    endtask

    task automatic test_back_to_back();
        int rises = 0;
        int last_rise = 0;
        logic [3:0] prev = 4'b0000;
        int budget = 256 * int'(2 + G) + 20;
        apply_reset();
        enc_y = 2'd3; enc_valid = 1'b1; ack = 1'b1;
        for (int cyc = 0; cyc < budget && rises < 256; cyc++) begin
            tick();
            if (gnt != 4'b0000 && prev == 4'b0000) begin
                rises++;
                checks++;
                if (gnt !== 4'b0001) begin
                    errors++;
                    $display("FAIL b2b_gnt rise=%0d got=%b exp=0001", rises, gnt);
                end
                if (rises > 1) begin
                    checks++;
                    if (cyc - last_rise != int'(2 + G)) begin
                        errors++;
                        $display("FAIL b2b_gap rise=%0d got=%0d exp=%0d",
                                 rises, cyc - last_rise, 2 + G);
                    end
                end
                last_rise = cyc;
            end
            prev = gnt;
        end
        checks++;
        if (rises != 256 || done_cnt !== 8'd255) begin
            errors++;
            $display("FAIL b2b_count got rises=%0d done=%0d exp 256/255", rises, done_cnt);
        end
        tick();
        enc_valid = 1'b0; ack = 1'b0;
        checks++;
        if (done_cnt !== 8'd0) begin
            errors++;
            $display("FAIL b2b_wrap got=%0d exp=0", done_cnt);
        end
        for (int i = 0; i < int'(G) + 2; i++) tick();
    endtask

    task automatic test_reset_mid_grant();
        int pulses = 0;
        int hi = 0;
        apply_reset();
        enc_y = 2'd0; enc_valid = 1'b1;
        tick();
        enc_valid = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < int'(G) + 1; i++) tick();
        enc_y = 2'd1; enc_valid = 1'b1;
        tick();
        enc_valid = 1'b0;
        tick(); tick();
        checks++;
        if (gnt !== 4'b0100 || done_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_pre got gnt=%b done=%0d exp 0100/1", gnt, done_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || done_cnt !== 8'd0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got gnt=%b done=%0d to=%b busy=%b exp 0000/0/0/0",
                     gnt, done_cnt, timeout_err, busy);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < int'(T + G) + 4; i++) begin
            if (timeout_err) pulses++;
            if (gnt != 4'b0000) hi++;
            tick();
        end
        checks++;
        if (pulses != 0 || hi != 0 || done_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_after got pulses=%0d gnt_cycles=%0d done=%0d exp 0/0/0",
                     pulses, hi, done_cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            enc_valid = ($urandom_range(0, 3) != 0);
            enc_y     = 2'($urandom_range(0, 3));
            ack       = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (gnt !== e_gnt) begin
                errors++;
                $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++;
                $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
            end
            checks++;
            if (timeout_err !== m_to) begin
                errors++;
                $display("FAIL rand_timeout cyc=%0d got=%b exp=%b", cyc, timeout_err, m_to);
            end
            checks++;
            if (done_cnt !== m_done) begin
                errors++;
                $display("FAIL rand_done cyc=%0d got=%0d exp=%0d", cyc, done_cnt, m_done);
            end
            checks++;
            if (gnt_idx !== m_idx) begin
                errors++;
                $display("FAIL rand_idx cyc=%0d got=%0d exp=%0d", cyc, gnt_idx, m_idx);
            end
        end
        rst = 1'b0; enc_valid = 1'b0; ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ack_grant();
        test_timeout();
        test_ack_at_timeout();
        test_back_to_back();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
